// File: rtl/ultrasword_jonz9_if.sv
// User-tile pin bundle for the ultrasword_jonz9 UART: dedicated inputs/outputs and the
// bidirectional byte lane.
interface ultrasword_jonz9_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/ultrasword_jonz9.sv
// Full-duplex 8N1 UART in the user-tile pinout: TX byte from uio_in on a tx_start_n falling
// edge, last RX byte shown a nibble at a time on uo_out[7:4] beside the line and status flags.
module ultrasword_jonz9 #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input logic          clk,
  input logic          rst,
  ultrasword_jonz9_if.slave io
);
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_e;

  // Synchronizer lanes: [0] rx, [1] tx_start_n, [2] rx_ack_n
  logic [2:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic       start_prev_q, start_prev_d;

  tx_state_e        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             tx_q, tx_d, tx_busy_q, tx_busy_d;

  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d, rx_ferr_q, rx_ferr_d;

  logic rx_s, start_n_s, ack_n_s;
  logic unused_inputs;

  assign rx_s      = sync2_q[0];
  assign start_n_s = sync2_q[1];
  assign ack_n_s   = sync2_q[2];
  assign unused_inputs = ^{io.ena, io.ui_in[7:4]};

  always_comb begin
    sync1_d      = {io.ui_in[3], io.ui_in[1], io.ui_in[0]};
    sync2_d      = sync1_q;
    start_prev_d = start_n_s;

    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    tx_busy_d  = tx_busy_q;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (start_prev_q && !start_n_s) begin
          tx_shift_d = io.uio_in;
          tx_cnt_d   = '0;
          tx_d       = 1'b0;
          tx_busy_d  = 1'b1;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        tx_cnt_d = tx_cnt_q + CNT_W'(1);
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_d       = tx_shift_q[0];
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        tx_cnt_d = tx_cnt_q + CNT_W'(1);
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_d       = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_d       = tx_shift_q[1];
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
          end
        end
      end
      TX_STOP: begin
        tx_cnt_d = tx_cnt_q + CNT_W'(1);
        if (tx_cnt_q == CNT_LAST) begin
          tx_busy_d  = 1'b0;
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase

    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_ferr_d  = rx_ferr_q;
    // Ack clears first so a same-cycle completed frame below wins
    rx_valid_d = ack_n_s ? rx_valid_q : 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        rx_cnt_d = rx_cnt_q + CNT_W'(1);
        if (rx_cnt_q == CNT_HALF) begin
          rx_cnt_d = '0;
          if (rx_s) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_ferr_d  = 1'b0;
            rx_valid_d = 1'b0;
            rx_bit_d   = '0;
            rx_state_d = RX_DATA;
          end
        end
      end
      RX_DATA: begin
        rx_cnt_d = rx_cnt_q + CNT_W'(1);
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        rx_cnt_d = rx_cnt_q + CNT_W'(1);
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d = '0;
          if (rx_s) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            rx_ferr_d  = 1'b1;
            rx_state_d = RX_WAIT_HIGH;
          end
        end
      end
      RX_WAIT_HIGH: if (rx_s) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= '1;
      sync2_q      <= '1;
      start_prev_q <= 1'b1;
      tx_state_q   <= TX_IDLE;
      tx_cnt_q     <= '0;
      tx_bit_q     <= '0;
      tx_shift_q   <= '0;
      tx_q         <= 1'b1;
      tx_busy_q    <= 1'b0;
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_ferr_q    <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      start_prev_q <= start_prev_d;
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_shift_q   <= tx_shift_d;
      tx_q         <= tx_d;
      tx_busy_q    <= tx_busy_d;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_ferr_q    <= rx_ferr_d;
    end
  end

  assign io.uo_out  = {(io.ui_in[2] ? rx_data_q[3:0] : rx_data_q[7:4]),
                       rx_ferr_q, rx_valid_q, tx_busy_q, tx_q};
  assign io.uio_out = '0;
  assign io.uio_oe  = '0;
endmodule

// File: tb/tb_ultrasword_jonz9.sv
// Directed plus randomized bench for the ultrasword_jonz9 UART tile, with a frame-level
// reference for the TX line and the RX data/flag state.
module tb_ultrasword_jonz9;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_pin = 1'b1, start_pin = 1'b1, nib_pin = 1'b1, ack_pin = 1'b1;
  logic [7:0] tx_byte = 8'h00;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_data  = 8'h00;
  logic       exp_valid = 1'b0;
  logic       exp_ferr  = 1'b0;

  ultrasword_jonz9_if u_if ();

  assign u_if.ena    = 1'b1;
  assign u_if.ui_in  = {4'h0, ack_pin, nib_pin, start_pin, rx_pin};
  assign u_if.uio_in = tx_byte;

  ultrasword_jonz9 #(.CLKS_PER_BIT(CPB)) dut (.clk(clk), .rst(rst), .io(u_if));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic chk_rx(input string tag);
    logic [3:0] nib;
    #1;
    nib = nib_pin ? exp_data[3:0] : exp_data[7:4];
    chk(tag, {u_if.uo_out[7:2], 2'b00}, {nib, exp_ferr, exp_valid, 2'b00});
  endtask

  task automatic rx_model(input logic [7:0] b, input logic stop);
    if (stop) begin
      exp_data  = b;
      exp_valid = 1'b1;
      exp_ferr  = 1'b0;
    end else begin
      exp_valid = 1'b0;
      exp_ferr  = 1'b1;
    end
  endtask

  // Drives one frame on the rx pin; the line is left at the stop-bit level.
  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_pin = f[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  // Starts a TX frame and checks latency, every bit cycle and the busy window.
  task automatic tx_frame(input logic [7:0] b, input bit retrig);
    logic [9:0] frame;
    int lat;
    frame   = {1'b1, b, 1'b0};
    tx_byte = b;
    start_pin = 1'b0;
    lat = 99;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 2) start_pin = 1'b1;
      if (lat == 99 && u_if.uo_out[0] == 1'b0) lat = k;
    end
    start_pin = 1'b1;
    chk("tx_latency_le4", {7'b0, lat <= 4}, 8'd1);
    if (lat > 4) return;
    for (int k = 6 - lat; k < 10 * CPB; k++) begin
      chk($sformatf("tx_bit%0d_cyc%0d", k / CPB, k % CPB),
          {6'b0, u_if.uo_out[1:0]}, {6'b0, 1'b1, frame[k / CPB]});
      if (retrig && k == 40) start_pin = 1'b0;
      if (retrig && k == 42) start_pin = 1'b1;
      @(negedge clk);
    end
    chk("tx_frame_end", {6'b0, u_if.uo_out[1:0]}, 8'h01);
  endtask

  initial begin
    rst = 1'b1;
    rx_pin = 1'b1; start_pin = 1'b1; nib_pin = 1'b1; ack_pin = 1'b1;
    tx_byte = 8'h00;
    repeat (16) @(negedge clk);
    chk("reset_uo_out", u_if.uo_out, 8'h01);
    chk("reset_uio_out", u_if.uio_out, 8'h00);
    chk("reset_uio_oe", u_if.uio_oe, 8'h00);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_reset_uo_out", u_if.uo_out, 8'h01);

    // TX 0xA5 with an ignored mid-frame start edge, then confirm nothing was queued
    tx_frame(8'hA5, 1'b1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("tx_no_requeue", {6'b0, u_if.uo_out[1:0]}, 8'h01);
    end

    // RX 0x3C, nibble select, then acknowledge
    send_rx(8'h3C, 1'b1);
    rx_model(8'h3C, 1'b1);
    nib_pin = 1'b1; chk_rx("rx_3c_low_nib");
    nib_pin = 1'b0; chk_rx("rx_3c_high_nib");
    ack_pin = 1'b0;
    repeat (4) @(negedge clk);
    ack_pin = 1'b1;
    exp_valid = 1'b0;
    chk_rx("rx_ack_clears_valid");
    repeat (8) @(negedge clk);

    // Frame error, line held low afterwards: no new reception until it idles high
    send_rx(8'h55, 1'b0);
    rx_model(8'h55, 1'b0);
    chk_rx("rx_frame_err");
    repeat (3 * CPB) @(negedge clk);
    chk_rx("rx_break_no_retrigger");
    rx_pin = 1'b1;
    repeat (6) @(negedge clk);
    chk_rx("rx_break_released");
    nib_pin = 1'b1;
    send_rx(8'h81, 1'b1);
    rx_model(8'h81, 1'b1);
    chk_rx("rx_81_after_err");

    // Glitch shorter than half a bit
    rx_pin = 1'b0;
    repeat (4) @(negedge clk);
    rx_pin = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    chk_rx("rx_glitch_ignored");

    // Full duplex
    fork
      tx_frame(8'hFF, 1'b0);
      send_rx(8'h00, 1'b1);
    join
    rx_model(8'h00, 1'b1);
    repeat (2) @(negedge clk);
    chk_rx("duplex_rx_00");

    // Randomized duplex traffic
    for (int n = 0; n < 4; n++) begin
      logic [7:0] tb_b, rb_b;
      tb_b = 8'($urandom);
      rb_b = 8'($urandom);
      nib_pin = 1'($urandom);
      fork
        tx_frame(tb_b, 1'b0);
        send_rx(rb_b, 1'b1);
      join
      rx_model(rb_b, 1'b1);
      repeat (2) @(negedge clk);
      chk_rx($sformatf("rand_rx_%0d", n));
    end

    // Reset 50 cycles into a TX frame
    tx_byte = 8'h00;
    start_pin = 1'b0;
    begin
      int waited;
      waited = 0;
      while (u_if.uo_out[0] !== 1'b0 && waited < 8) begin
        @(negedge clk);
        waited++;
      end
      chk("rst_tx_started", {7'b0, u_if.uo_out[0]}, 8'h00);
    end
    start_pin = 1'b1;
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    exp_data = 8'h00; exp_valid = 1'b0; exp_ferr = 1'b0;
    chk("rst_mid_tx_line", {6'b0, u_if.uo_out[1:0]}, 8'h01);
    chk("rst_mid_tx_uo_out", u_if.uo_out, 8'h01);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
